// File: rtl/ozturk_seq_multiplier.sv
// Sequential Ozturk limb multiplier: R rows of B per cycle into column accumulators, then two carry-save passes.
// Optional macro OZTURK_SEQ_MUL_SQUARE_EN adds a 'square' input that forces B := A on acceptance.
module ozturk_seq_multiplier #(
  parameter int NUM_ELEMENTS   = 17,
  parameter int BIT_LEN        = 17,
  parameter int WORD_LEN       = 16,
  parameter int ROWS_PER_CYCLE = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BIT_LEN-1:0] A [NUM_ELEMENTS],
  input  logic [BIT_LEN-1:0] B [NUM_ELEMENTS],
`ifdef OZTURK_SEQ_MUL_SQUARE_EN
  input  logic               square,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BIT_LEN-1:0] M [2*NUM_ELEMENTS+1]
);
  localparam int N       = NUM_ELEMENTS;
  localparam int W       = WORD_LEN;
  localparam int R       = ROWS_PER_CYCLE;
  localparam int C       = (N + R - 1) / R;
  localparam int ACC_LEN = 2 * BIT_LEN + $clog2(N);
  localparam int RW      = $clog2(C + 1);

  typedef logic [BIT_LEN-1:0] limb_t;
  typedef logic [ACC_LEN-1:0] acc_t;
  typedef logic [W+1:0]       tw_t;
  typedef logic [RW-1:0]      row_t;
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_NORM, S_DONE} state_t;

  if (BIT_LEN < WORD_LEN + 1) begin : g_chk_bitlen
    $error("ozturk_seq_multiplier: BIT_LEN must be at least WORD_LEN+1");
  end
  if (2 * (BIT_LEN - WORD_LEN) + $clog2(NUM_ELEMENTS) > WORD_LEN) begin : g_chk_headroom
    $error("ozturk_seq_multiplier: accumulator top slice does not fit in one word");
  end
  if (ROWS_PER_CYCLE < 1 || ROWS_PER_CYCLE > NUM_ELEMENTS) begin : g_chk_rows
    $error("ozturk_seq_multiplier: ROWS_PER_CYCLE out of range");
  end

  state_t state_q, state_d;
  logic   phase_q, phase_d;
  row_t   r_q, r_d;
  limb_t  a_q [N];
  limb_t  b_q [N];
  acc_t   acc_q [2*N-1];
  acc_t   acc_d [2*N-1];
  tw_t    t_q [2*N+1];
  tw_t    t_d [2*N+1];
  limb_t  m_q [2*N+1];
  limb_t  m_d [2*N+1];
  logic   accept;

  assign in_ready  = (state_q == S_IDLE) && !rst;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == S_DONE);
  assign M         = m_q;

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    r_d     = r_q;
    case (state_q)
      S_IDLE: if (in_valid) begin
        state_d = S_MUL;
        r_d     = '0;
      end
      S_MUL: begin
        r_d = r_q + row_t'(1);
        if (r_q == row_t'(C - 1)) begin
          state_d = S_NORM;
          phase_d = 1'b0;
        end
      end
      // Two NORM cycles: first registers t, second registers M and enters DONE.
      S_NORM: begin
        phase_d = 1'b1;
        if (phase_q) begin
          state_d = S_DONE;
          phase_d = 1'b0;
        end
      end
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Row group r: one B limb per row offset, broadcast against every A limb.
  acc_t  prod [N];
  limb_t brow;
  int    row;
  always_comb begin
    acc_d = acc_q;
    prod  = '{default: '0};
    brow  = '0;
    row   = 0;
    for (int o = 0; o < R; o++) begin
      row  = int'(r_q) * R + o;
      brow = '0;
      for (int n = 0; n < N; n++)
        if (row == n) brow = b_q[n];
      for (int i = 0; i < N; i++)
        prod[i] = acc_t'(a_q[i]) * acc_t'(brow);
      for (int i = 0; i < N; i++)
        for (int k = 0; k < 2*N-1; k++)
          if (k == i + row) acc_d[k] = acc_d[k] + prod[i];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi <= 2*N; gi++) begin : g_norm
      tw_t lo, mid, hi;
      if (gi <= 2*N-2) begin : g_lo
        assign lo = tw_t'(acc_q[gi][W-1:0]);
      end else begin : g_lo_z
        assign lo = '0;
      end
      if (gi >= 1 && gi <= 2*N-1) begin : g_mid
        assign mid = tw_t'(acc_q[gi-1][2*W-1:W]);
      end else begin : g_mid_z
        assign mid = '0;
      end
      if (gi >= 2) begin : g_hi
        assign hi = tw_t'(acc_q[gi-2][ACC_LEN-1:2*W]);
      end else begin : g_hi_z
        assign hi = '0;
      end
      assign t_d[gi] = lo + mid + hi;
      if (gi >= 1) begin : g_m
        assign m_d[gi] = limb_t'(t_q[gi][W-1:0]) + limb_t'(t_q[gi-1][W+1:W]);
      end else begin : g_m0
        assign m_d[gi] = limb_t'(t_q[gi][W-1:0]);
      end
    end
  endgenerate

  // The top column's carry bits are provably zero, so they have no destination.
  logic unused_top_carry;
  assign unused_top_carry = |t_q[2*N][W+1:W];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      phase_q <= 1'b0;
      r_q     <= '0;
      acc_q   <= '{default: '0};
      t_q     <= '{default: '0};
      m_q     <= '{default: '0};
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      r_q     <= r_d;
      if (accept)                  acc_q <= '{default: '0};
      else if (state_q == S_MUL)   acc_q <= acc_d;
      if (state_q == S_NORM && !phase_q) t_q <= t_d;
      if (state_q == S_NORM &&  phase_q) m_q <= m_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= A;
`ifdef OZTURK_SEQ_MUL_SQUARE_EN
      b_q <= square ? A : B;
`else
      b_q <= B;
`endif
    end
  end
endmodule

// File: tb/tb_ozturk_seq_multiplier.sv
// Scoreboard bench for ozturk_seq_multiplier: three instances (R = 1, 4, 17) share one stimulus stream.
module tb_ozturk_seq_multiplier;
  localparam int N  = 17;
  localparam int W  = 16;
  localparam int BL = 17;
  localparam int NM = 2*N+1;
  typedef logic [BL-1:0] limb_t;
  typedef logic [575:0]  big_t;

  logic  clk = 1'b0;
  logic  rst, in_valid, out_ready;
  limb_t a_s [N];
  limb_t b_s [N];
  logic  rdy1, rdy4, rdy17, ov1, ov4, ov17;
  limb_t m1  [NM];
  limb_t m4  [NM];
  limb_t m17 [NM];
`ifdef OZTURK_SEQ_MUL_SQUARE_EN
  logic  square_s;
`endif

  int    cyc = 0;
  int    n_checks = 0;
  int    n_fail = 0;
  int    start_cyc = 0;
  big_t  exp_q [3][$];
  int    lat_exp [3] = '{19, 7, 3};
  int    rows [3] = '{1, 4, 17};
  logic  prev_ov [3];
  limb_t op_a [N];
  limb_t op_b [N];
  limb_t mcap [NM];
  logic  seen_ov;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ozturk_seq_multiplier #(.NUM_ELEMENTS(N), .BIT_LEN(BL), .WORD_LEN(W), .ROWS_PER_CYCLE(1)) u_r1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .A(a_s), .B(b_s),
`ifdef OZTURK_SEQ_MUL_SQUARE_EN
    .square(square_s),
`endif
    .out_valid(ov1), .out_ready(out_ready), .M(m1));
  ozturk_seq_multiplier #(.NUM_ELEMENTS(N), .BIT_LEN(BL), .WORD_LEN(W), .ROWS_PER_CYCLE(4)) u_r4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy4), .A(a_s), .B(b_s),
`ifdef OZTURK_SEQ_MUL_SQUARE_EN
    .square(square_s),
`endif
    .out_valid(ov4), .out_ready(out_ready), .M(m4));
  ozturk_seq_multiplier #(.NUM_ELEMENTS(N), .BIT_LEN(BL), .WORD_LEN(W), .ROWS_PER_CYCLE(17)) u_r17 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy17), .A(a_s), .B(b_s),
`ifdef OZTURK_SEQ_MUL_SQUARE_EN
    .square(square_s),
`endif
    .out_valid(ov17), .out_ready(out_ready), .M(m17));

  task automatic check(input string tag, input big_t got, input big_t want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic big_t op_val(input limb_t x [N]);
    big_t v = '0;
    for (int i = 0; i < N; i++) v = v + (big_t'(x[i]) << (W*i));
    return v;
  endfunction

  function automatic big_t m_val(input limb_t x [NM]);
    big_t v = '0;
    for (int k = 0; k < NM; k++) v = v + (big_t'(x[k]) << (W*k));
    return v;
  endfunction

  task automatic mon(input int idx, input logic ov, input limb_t m [NM]);
    big_t want;
    if (rst) begin
      prev_ov[idx] = 1'b0;
    end else begin
      if (ov && !prev_ov[idx])
        check($sformatf("latency_r%0d", rows[idx]), big_t'(cyc - start_cyc), big_t'(lat_exp[idx]));
      if (ov && out_ready) begin
        check($sformatf("expected_txn_r%0d", rows[idx]), big_t'(exp_q[idx].size() != 0), big_t'(1));
        if (exp_q[idx].size() != 0) begin
          want = exp_q[idx].pop_front();
          check($sformatf("product_r%0d", rows[idx]), m_val(m), want);
          $display("[TB] R=%0d product received at cycle %0d", rows[idx], cyc);
        end
      end
      prev_ov[idx] = ov;
    end
  endtask

  always @(negedge clk) mon(0, ov1, m1);
  always @(negedge clk) mon(1, ov4, m4);
  always @(negedge clk) mon(2, ov17, m17);

  // Called just after a rising edge; the acceptance happens on the next one.
  task automatic start_txn(input bit sq);
    big_t av, bv;
    a_s = op_a;
    b_s = op_b;
`ifdef OZTURK_SEQ_MUL_SQUARE_EN
    square_s = sq;
`endif
    av = op_val(op_a);
    bv = sq ? av : op_val(op_b);
    check("ready_before_start", big_t'({rdy1, rdy4, rdy17}), big_t'(3'b111));
    for (int i = 0; i < 3; i++) exp_q[i].push_back(av * bv);
    start_cyc = cyc + 1;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      a_s[i] = limb_t'($urandom);
      b_s[i] = limb_t'($urandom);
    end
  endtask

  task automatic drain();
    int k = 0;
    while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0 && k < 300) begin
      @(posedge clk); #1;
      k++;
    end
    check("drain", big_t'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size()), big_t'(0));
  endtask

  task automatic wait_ov1();
    int k = 0;
    while (!ov1 && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    check("out_valid_r1_seen", big_t'(ov1), big_t'(1));
  endtask

  task automatic fill_ops(input int mode);
    for (int i = 0; i < N; i++) begin
      op_a[i] = (mode == 1) ? limb_t'(17'h1FFFF) : limb_t'($urandom);
      op_b[i] = (mode == 1) ? limb_t'(17'h1FFFF) : limb_t'($urandom);
      if (mode == 0) begin
        op_a[i] = '0;
        op_b[i] = '0;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < N; i++) begin a_s[i] = '0; b_s[i] = '0; end
`ifdef OZTURK_SEQ_MUL_SQUARE_EN
    square_s = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", big_t'({ov1, ov4, ov17}), big_t'(0));
    check("reset_in_ready", big_t'({rdy1, rdy4, rdy17}), big_t'(0));
    check("reset_m", m_val(m1) | m_val(m4) | m_val(m17), big_t'(0));
    rst = 1'b0;
    @(posedge clk); #1;
    check("in_ready_after_reset", big_t'({rdy1, rdy4, rdy17}), big_t'(3'b111));

    // Single limb product
    fill_ops(0); op_a[0] = 17'd1; op_b[0] = 17'd1;
    start_txn(1'b0);
    wait_ov1();
    check("unit_m0", big_t'(m1[0]), big_t'(1));
    check("unit_m1", big_t'(m1[1]), big_t'(0));
    drain();

    // Redundant single limb
    fill_ops(0); op_a[0] = 17'h1FFFF; op_b[0] = 17'h1FFFF;
    start_txn(1'b0);
    wait_ov1();
    check("redundant_m0", big_t'(m1[0]), big_t'(17'h00001));
    check("redundant_m1", big_t'(m1[1]), big_t'(17'h0FFFC));
    check("redundant_m2", big_t'(m1[2]), big_t'(17'h00003));
    check("redundant_m3", big_t'(m1[3]), big_t'(0));
    drain();

    // Full scale, with a stray in_valid pulse while every instance is busy
    fill_ops(1);
    start_txn(1'b0);
    @(posedge clk); #1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();

    // Backpressure then chaining
    fill_ops(2);
    out_ready = 1'b0;
    start_txn(1'b0);
    wait_ov1();
    mcap = m1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("hold_m_stable", m_val(m1), m_val(mcap));
      check("hold_out_valid", big_t'(ov1), big_t'(1));
      check("hold_in_ready_low", big_t'(rdy1), big_t'(0));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("in_ready_after_handshake", big_t'(rdy1), big_t'(1));
    drain();
    for (int i = 0; i < N; i++) begin
      op_a[i] = mcap[i];
      op_b[i] = limb_t'($urandom);
    end
    start_txn(1'b0);
    drain();

    // Reset during MUL cycle 5
    fill_ops(2);
    start_txn(1'b0);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) exp_q[i].delete();
    seen_ov = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (ov1) seen_ov = 1'b1;
    end
    check("abort_no_out_valid", big_t'(seen_ov), big_t'(0));
    check("abort_m_cleared", m_val(m1), big_t'(0));
    fill_ops(2);
    start_txn(1'b0);
    drain();

`ifdef OZTURK_SEQ_MUL_SQUARE_EN
    fill_ops(0); op_a[0] = 17'd3; op_b[0] = 17'd7;
    start_txn(1'b1);
    wait_ov1();
    check("square_m0", big_t'(m1[0]), big_t'(9));
    drain();
`endif

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end
endmodule
